rct_m2w_bridge: RTL and testbench
=================================

// Module: rct_m2w_bridge
// PURPOSE
//  mem_if-to-Wishbone master bridge; the counterpart of the W2M slave bridge.
//  - Accepts one mem_if request (valid/ready, 87b packet).
//  - Runs it as one classic Wishbone master cycle.
//  - Returns a 51b mem_if response carrying the request TID.
//  - Lets rct_* mem_if initiators reach Wishbone peripherals. One outstanding transaction.
// PARAMETERS
//  BUS_WIDTH    32   Wishbone address/data width (mem_if fields fixed at 32)
//  BUS_MASK     4    Wishbone byte-select width
//  TIMEOUT_CYC  255  bus-wait limit in cycles (used only with RCT_M2W_TIMEOUT_EN), 1..255
// PORTS
//  clk_i              in   1   clock; all logic on rising edge
//  rst_i              in   1   synchronous reset, active-high
//  mem_if_req_valid   in   1   request valid
//  mem_if_req_ready   out  1   request ready
//  mem_if_req         in   87  {tid[15:0],we,addr[31:0],data[31:0],mask[3:0],rsvd[1:0]}
//                              tid={rid[3:0],srcid[3:0],tid[7:0]}
//  mem_if_resp_valid  out  1   response valid
//  mem_if_resp_ready  in   1   response ready
//  mem_if_resp        out  51  {tid[15:0],data[31:0],err,rsvd[1:0]}; rsvd=0
//  wb_cyc_o           out  1   Wishbone cycle
//  wb_stb_o           out  1   Wishbone strobe
//  wb_we_o            out  1   write enable
//  wb_adr_o           out  32  address, full byte address passed unmodified
//  wb_dat_o           out  32  write data
//  wb_sel_o           out  4   byte selects = req mask, passed unmodified (0 allowed)
//  wb_ack_i           in   1   slave acknowledge
//  wb_err_i           in   1   slave error
//  wb_dat_i           in   32  read data
// BEHAVIOUR
//  FSM states: IDLE, BUS, RESP. All outputs registered except mem_if_req_ready.
//  - mem_if_req_ready = (state==IDLE).
//  Reset values:
//  - state=IDLE; cyc/stb/we=0; adr/dat/sel=0.
//  - resp_valid=0; resp=0; timeout counter=0.
//  IDLE:
//  - On req_valid&req_ready: latch tid/we/addr/data/mask; next edge go to BUS.
//  - In BUS, wb_cyc_o=wb_stb_o=1 with latched fields.
//  BUS: cyc/stb stay high, fields stable, until wb_ack_i|wb_err_i is sampled high.
//  On termination, next edge:
//  - cyc=stb=0; go to RESP; resp_valid=1.
//  - resp.tid = latched tid.
//  - resp.data = wb_dat_i for reads, 0 for writes.
//  - resp.err = wb_err_i.
//  Boundary cases:
//  - ack and err in the same cycle: err wins (err=1, data=0).
//  - ack/err while cyc=0: ignored.
//  RESP: hold resp stable while !resp_ready; on resp_ready go to IDLE, resp_valid=0.
//  Latency:
//  - Accept at edge N; cyc/stb high after N.
//  - Earliest ack sampled at N+1; resp_valid high after N+1.
//  - Back-to-back request accepted no earlier than 1 cycle after the response handshake.
//  Minimum 3 cycles per transaction.
//  Reset mid-operation:
//  - Next edge forces the reset values and drops cyc/stb.
//  - In-flight transaction discarded; no response emitted.
// CONFIGURATION
//  RCT_M2W_TIMEOUT_EN defined:
//  - 8b counter clears on entering BUS and increments each BUS cycle without ack/err.
//  - When counter==TIMEOUT_CYC and no ack/err that cycle: drop cyc/stb, go RESP with err=1, data=0.
//  - ack/err in the same cycle as the limit: the slave termination wins.
//  RCT_M2W_TIMEOUT_EN undefined:
//  - No counter logic; BUS waits indefinitely.
// TESTING
//  1. Read: req{tid=16'h1234,we=0,addr=32'h8000_0010,mask=4'hF}, ack after 2 wait cycles
//     with dat 32'hDEAD_BEEF -> resp{tid=16'h1234,data=32'hDEAD_BEEF,err=0},
//     cyc/stb high exactly 3 cycles.
//  2. Write: we=1, addr 32'h8000_0004, data 32'hA5A5_0F0F, mask 4'h3, same-cycle ack
//     -> wb_dat_o/wb_sel_o match; resp data=0, err=0; resp_valid one cycle after accept+1.
//  3. Response backpressure: hold resp_ready=0 for 5 cycles -> resp stable,
//     req_ready=0 throughout; second req accepted only after the handshake.
//  4. Slave error: wb_err_i=1 together with wb_ack_i=1 -> resp err=1, data=0;
//     cyc drops next edge.
//  5. rst_i pulsed while in BUS -> next edge cyc/stb=0, no resp_valid, req_ready=1.
//  6. RCT_M2W_TIMEOUT_EN, TIMEOUT_CYC=4, slave never acks -> err resp after 5 BUS cycles;
//     without the macro, cyc stays high for 1000 cycles.

Source files
------------

// File: rtl/rct_m2w_bridge_if.sv
// rct_m2w_bridge_if: mem_if request/response plus Wishbone master signals of the M2W bridge
interface rct_m2w_bridge_if #(parameter int BUS_WIDTH = 32, parameter int BUS_MASK = 4);
  logic                 mem_if_req_valid;
  logic                 mem_if_req_ready;
  logic [86:0]          mem_if_req;
  logic                 mem_if_resp_valid;
  logic                 mem_if_resp_ready;
  logic [50:0]          mem_if_resp;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [BUS_WIDTH-1:0] wb_adr_o;
  logic [BUS_WIDTH-1:0] wb_dat_o;
  logic [BUS_MASK-1:0]  wb_sel_o;
  logic                 wb_ack_i;
  logic                 wb_err_i;
  logic [BUS_WIDTH-1:0] wb_dat_i;
  modport master (
    input  mem_if_req_valid, mem_if_req, mem_if_resp_ready, wb_ack_i, wb_err_i, wb_dat_i,
    output mem_if_req_ready, mem_if_resp_valid, mem_if_resp,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
  modport slave (
    output mem_if_req_valid, mem_if_req, mem_if_resp_ready, wb_ack_i, wb_err_i, wb_dat_i,
    input  mem_if_req_ready, mem_if_resp_valid, mem_if_resp,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/rct_m2w_bridge.sv
// rct_m2w_bridge: mem_if to classic Wishbone master bridge, one outstanding transaction; RCT_M2W_TIMEOUT_EN adds a bus-wait timeout
module rct_m2w_bridge #(
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_MASK    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk_i,
  input logic rst_i,
  rct_m2w_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_nx;
  logic acc, term, to, err_nx;
  logic [15:0] tid;
  logic unused;
  assign unused = &{1'b0, bus.mem_if_req[1:0]};
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE && acc) ? BUS :
               (state == BUS && term) ? RESP :
               (state == RESP && bus.mem_if_resp_ready) ? IDLE : state;
  end
  always_comb begin
    bus.mem_if_req_ready = state == IDLE;
    acc    = bus.mem_if_req_ready & bus.mem_if_req_valid;
    term   = (state == BUS) & ((bus.wb_ack_i | bus.wb_err_i) | to);
    err_nx = bus.wb_err_i | to;
  end
`ifdef RCT_M2W_TIMEOUT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk_i)
    if (rst_i || acc) cnt <= 8'd0;
    else if (state == BUS && !(bus.wb_ack_i | bus.wb_err_i)) cnt <= cnt + 8'd1;
  // slave termination in the limit cycle takes precedence over the timeout
  assign to = state == BUS && cnt == 8'(TIMEOUT_CYC) && !(bus.wb_ack_i | bus.wb_err_i);
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (rst_i) begin
      tid                   <= '0;
      bus.wb_cyc_o          <= 1'b0;
      bus.wb_stb_o          <= 1'b0;
      bus.wb_we_o           <= 1'b0;
      bus.wb_adr_o          <= '0;
      bus.wb_dat_o          <= '0;
      bus.wb_sel_o          <= '0;
      bus.mem_if_resp_valid <= 1'b0;
      bus.mem_if_resp       <= '0;
    end else if (acc) begin
      tid          <= bus.mem_if_req[86:71];
      bus.wb_we_o  <= bus.mem_if_req[70];
      bus.wb_adr_o <= BUS_WIDTH'(bus.mem_if_req[69:38]);
      bus.wb_dat_o <= BUS_WIDTH'(bus.mem_if_req[37:6]);
      bus.wb_sel_o <= BUS_MASK'(bus.mem_if_req[5:2]);
      bus.wb_cyc_o <= 1'b1;
      bus.wb_stb_o <= 1'b1;
    end else if (term) begin
      bus.wb_cyc_o          <= 1'b0;
      bus.wb_stb_o          <= 1'b0;
      bus.mem_if_resp_valid <= 1'b1;
      bus.mem_if_resp       <= {tid, (err_nx | bus.wb_we_o) ? 32'd0 : 32'(bus.wb_dat_i), err_nx, 2'b00};
    end else if (state == RESP && bus.mem_if_resp_ready) begin
      bus.mem_if_resp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rct_m2w_bridge.sv
// tb_rct_m2w_bridge: randomized self-checking bench acting as mem_if initiator and Wishbone slave
module tb_rct_m2w_bridge;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  rct_m2w_bridge_if bus ();
  rct_m2w_bridge #(.TIMEOUT_CYC(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [50:0] model_resp(input logic [15:0] tid, input logic we, input logic err,
                                             input logic [31:0] rd);
    logic [31:0] d;
    d = (err || we) ? 32'd0 : rd;
    return {tid, d, err, 2'b00};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wb_ack_i = 1'($urandom);
      bus.wb_err_i = 1'($urandom);
      bus.wb_dat_i = $urandom;
      @(negedge clk);
      chk("idle_cyc", {62'd0, bus.wb_cyc_o, bus.mem_if_resp_valid}, 64'd0);
      chk("idle_ready", 64'(bus.mem_if_req_ready), 64'd1);
      @(posedge clk); #1;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
    end
  endtask

  task automatic send_req(input logic [15:0] tid, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask);
    bus.mem_if_req = {tid, we, addr, data, mask, 2'($urandom)};
    bus.mem_if_req_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", {62'd0, bus.mem_if_req_ready, bus.mem_if_resp_valid}, 64'd2);
    @(posedge clk); #1;
    bus.mem_if_req_valid = 1'b0;
    bus.mem_if_req = {$urandom, $urandom, $urandom};
  endtask

  task automatic txn(input logic [15:0] tid, input logic we, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] mask, input int waits,
                     input logic err, input logic ack_too, input int bp);
    logic [31:0] rd;
    logic [50:0] exp;
    rd = $urandom;
    exp = model_resp(tid, we, err, rd);
    send_req(tid, we, addr, data, mask);
    for (int i = 0; i <= waits; i++) begin
      bus.wb_ack_i = (i == waits) && (ack_too || !err);
      bus.wb_err_i = (i == waits) && err;
      bus.wb_dat_i = (i == waits) ? rd : $urandom;
      @(negedge clk);
      chk("bus_cyc_stb", {61'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.mem_if_req_ready}, 64'd6);
      chk("bus_fields", {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o[30:0]}, {we, addr, data[30:0]});
      chk("bus_sel_d31", {59'd0, bus.wb_sel_o, bus.wb_dat_o[31]}, {59'd0, mask, data[31]});
      chk("bus_no_resp", 64'(bus.mem_if_resp_valid), 64'd0);
      @(posedge clk); #1;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
    end
    bus.mem_if_resp_ready = 1'b0;
    bus.mem_if_req_valid = (bp > 0);
    for (int j = 0; j <= bp; j++) begin
      @(negedge clk);
      chk("resp_valid_cyc", {61'd0, bus.mem_if_resp_valid, bus.wb_cyc_o, bus.mem_if_req_ready}, 64'd4);
      chk("resp_data", 64'(bus.mem_if_resp), 64'(exp));
      if (j < bp) begin
        @(posedge clk); #1;
      end
    end
    bus.mem_if_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_if_resp_ready = 1'($urandom);
    bus.mem_if_req_valid = 1'b0;
  endtask

  initial begin
    int n;
    bit done;
    bus.mem_if_req_valid = 1'b0;
    bus.mem_if_req = '0;
    bus.mem_if_resp_ready = 1'b0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {59'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.mem_if_resp_valid, bus.mem_if_req_ready}, 64'd1);
    chk("rst_bus", {bus.wb_adr_o, bus.wb_dat_o}, 64'd0);
    chk("rst_sel", 64'(bus.wb_sel_o), 64'd0);
    chk("rst_resp", 64'(bus.mem_if_resp), 64'd0);
    @(posedge clk); #1;
    txn(16'h1234, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 2, 1'b0, 1'b0, 0);
    txn(16'h5678, 1'b1, 32'h8000_0004, 32'hA5A5_0F0F, 4'h3, 0, 1'b0, 1'b0, 0);
    txn(16'h9ABC, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 1'b0, 1'b0, 5);
    txn(16'h0042, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hC, 1, 1'b1, 1'b1, 0);
    for (int k = 0; k < 40; k++) begin
      idle_cycles($urandom_range(0, 2));
      txn(16'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 4),
          ($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 3));
    end
    // reset while a transaction is on the bus
    send_req(16'hBEEF, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_if_resp_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_ctrl", {61'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.mem_if_req_ready}, 64'd1);
    chk("rstmid_adr", 64'(bus.wb_adr_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid_noresp", {62'd0, bus.mem_if_resp_valid, bus.wb_cyc_o}, 64'd0);
    end
    @(posedge clk); #1;
    txn(16'h7777, 1'b0, 32'h2000_0008, 32'h0, 4'hF, 1, 1'b0, 1'b0, 1);
    // silent slave
    send_req(16'hC0DE, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
    n = 0;
    done = 1'b0;
`ifdef RCT_M2W_TIMEOUT_EN
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) n++;
      else begin
        done = 1'b1;
        chk("to_resp_valid", 64'(bus.mem_if_resp_valid), 64'd1);
        chk("to_resp", 64'(bus.mem_if_resp), 64'(model_resp(16'hC0DE, 1'b0, 1'b1, 32'h0)));
      end
      @(posedge clk); #1;
    end
    chk("to_bus_cycles", 64'(n), 64'(TO + 1));
    bus.mem_if_resp_ready = 1'b1;
    @(posedge clk); #1;
`else
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o && !bus.mem_if_resp_valid) n++;
      @(posedge clk); #1;
    end
    chk("no_to_wait", 64'(n), 64'd1000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    @(negedge clk);
    chk("end_idle", {62'd0, bus.wb_cyc_o, bus.mem_if_req_ready}, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
